// File: rtl/hilo_mdu_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit.
//   mdu_op_e    : operation encodings driven on the op port
//   mdu_state_e : sequencer state encodings
//   mdu_ctx_t   : per-operation context latched when an operation is accepted
package hilo_mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } mdu_state_e;

  // Everything the final fix-up needs once the iterations are finished.
  typedef struct packed {
    logic is_div;
    logic neg_a;     // signed op with a negative rs operand
    logic neg_b;     // signed op with a negative rt operand
    logic div_zero;  // divide with a zero divisor
  } mdu_ctx_t;

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_mdu_step.sv
// mdu_step: one radix-2 iteration on unsigned magnitudes.
//   is_div  : 1 restoring-divide step, 0 shift-add multiply step
//   acc_in  : partial remainder (divide) / upper product half (multiply)
//   q_in    : dividend-then-quotient (divide) / multiplier-then-lower product (multiply)
//   b_in    : divisor / multiplicand magnitude
//   acc_out, q_out : register contents after this iteration
module mdu_step #(
  parameter int unsigned data_width = 32
) (
  input  logic                  is_div,
  input  logic [data_width-1:0] acc_in,
  input  logic [data_width-1:0] q_in,
  input  logic [data_width-1:0] b_in,
  output logic [data_width-1:0] acc_out,
  output logic [data_width-1:0] q_out
);

  localparam int unsigned DW = data_width;

  logic [DW:0]   add_sum;
  logic [DW:0]   shifted;
  logic          fits;
  logic [DW-1:0] sub_res;

  always_comb begin
    add_sum = {1'b0, acc_in} + {1'b0, b_in};
    shifted = {acc_in, q_in[DW-1]};
    fits    = (shifted >= {1'b0, b_in});
    // When the divisor fits, the difference is below the divisor, so DW bits suffice.
    sub_res = shifted[DW-1:0] - b_in;
    acc_out = acc_in;
    q_out   = q_in;
    if (is_div) begin
      if (fits) begin
        acc_out = sub_res;
        q_out   = {q_in[DW-2:0], 1'b1};
      end else begin
        acc_out = shifted[DW-1:0];
        q_out   = {q_in[DW-2:0], 1'b0};
      end
    end else begin
      // Add multiplicand when the multiplier LSB is set, then shift {acc,q} right.
      if (q_in[0]) begin
        acc_out = add_sum[DW:1];
        q_out   = {add_sum[0], q_in[DW-1:1]};
      end else begin
        acc_out = {1'b0, acc_in[DW-1:1]};
        q_out   = {acc_in[0], q_in[DW-1:1]};
      end
    end
  end

endmodule

// File: rtl/hilo_mdu.sv
// hilo_mdu: iterative HI/LO multiply/divide unit, one bit per cycle.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, op          : request and operation (sampled only when idle)
//   rs_val, rt_val     : multiplicand/dividend, multiplier/divisor
//   mthi, mtlo, wdata  : direct HI/LO writes, honoured only when idle
//   flush              : cancel an in-flight calculation
//   hilo_sel, rd_data  : combinational HI (1) / LO (0) read port
//   busy, done         : not-idle flag, one-cycle completion pulse
//   hi, lo             : architectural HI/LO registers
module hilo_mdu
  import hilo_mdu_pkg::*;
#(
  parameter int unsigned data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [data_width-1:0] rs_val,
  input  logic [data_width-1:0] rt_val,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [data_width-1:0] wdata,
  input  logic                  flush,
  input  logic                  hilo_sel,
  output logic [data_width-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo
);

  localparam int unsigned DW    = data_width;
  localparam int unsigned PW    = 2 * data_width;
  localparam int unsigned CNT_W = $clog2(data_width);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(data_width - 1);

  mdu_state_e     state;
  logic [CNT_W-1:0] iter_cnt;
  mdu_ctx_t       ctx;
  logic [DW-1:0]  acc;
  logic [DW-1:0]  q;
  logic [DW-1:0]  b;
  logic [DW-1:0]  dividend;

  logic [DW-1:0]  acc_nxt;
  logic [DW-1:0]  q_nxt;

  // Operand preparation for a newly accepted operation.
  mdu_op_e        op_e;
  logic           op_signed;
  logic           rs_neg;
  logic           rt_neg;
  logic [DW-1:0]  rs_mag;
  logic [DW-1:0]  rt_mag;

  // Sign/zero fix-up of the final iteration's result.
  logic [PW-1:0]  prod_mag;
  logic [PW-1:0]  prod;
  logic [DW-1:0]  quot;
  logic [DW-1:0]  rem;
  logic [DW-1:0]  hi_commit;
  logic [DW-1:0]  lo_commit;

  mdu_step #(.data_width(DW)) u_step (
    .is_div  (ctx.is_div),
    .acc_in  (acc),
    .q_in    (q),
    .b_in    (b),
    .acc_out (acc_nxt),
    .q_out   (q_nxt)
  );

  // Magnitudes of the incoming operands.
  always_comb begin
    op_e      = mdu_op_e'(op);
    op_signed = op_is_signed(op_e);
    rs_neg    = op_signed & rs_val[DW-1];
    rt_neg    = op_signed & rt_val[DW-1];
    rs_mag    = rs_neg ? DW'(-rs_val) : rs_val;
    rt_mag    = rt_neg ? DW'(-rt_val) : rt_val;
  end

  // Result fix-up applied on the last iteration.
  always_comb begin
    prod_mag  = {acc_nxt, q_nxt};
    prod      = (ctx.neg_a ^ ctx.neg_b) ? PW'(-prod_mag) : prod_mag;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot      = (ctx.neg_a ^ ctx.neg_b) ? DW'(-q_nxt) : q_nxt;
    rem       = ctx.neg_a ? DW'(-acc_nxt) : acc_nxt;
    hi_commit = prod[PW-1:DW];
    lo_commit = prod[DW-1:0];
    if (ctx.is_div) begin
      if (ctx.div_zero) begin
        hi_commit = dividend;
        lo_commit = '1;
      end else begin
        hi_commit = rem;
        lo_commit = quot;
      end
    end
  end

  // Sequencer, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      ctx      <= '0;
      acc      <= '0;
      q        <= '0;
      b        <= '0;
      dividend <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            state        <= ST_CALC;
            busy         <= 1'b1;
            iter_cnt     <= '0;
            ctx.is_div   <= op_is_div(op_e);
            ctx.neg_a    <= rs_neg;
            ctx.neg_b    <= rt_neg;
            ctx.div_zero <= (rt_val == '0);
            acc          <= '0;
            q            <= rs_mag;
            b            <= rt_mag;
            dividend     <= rs_val;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc      <= acc_nxt;
            q        <= q_nxt;
            iter_cnt <= iter_cnt + CNT_W'(1);
            if (iter_cnt == LAST_ITER) begin
              hi    <= hi_commit;
              lo    <= lo_commit;
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign rd_data = hilo_sel ? hi : lo;

endmodule
